// File: rtl/chroni_pixel_expander.sv
// chroni_pixel_expander
// Serialises one 1bpp bitmap byte, MSB first, into 1..8 palette-index writes
// to the 2-line pixel RAM, one pixel per clock. wr_busy stalls the font fetch
// FSM while a multi-pixel expansion is in flight. A bit count of 0 selects
// direct mode: wr_data itself is written as a single palette index.
// Writes to pixel indices >= BUF_SIZE are dropped without disturbing timing.
//
// Build option: CHRONI_EXPANDER_TRANSPARENT_EN -- when defined, a latched
// off-index of 8'h00 makes 0 bits transparent (no write; address still steps).

module chroni_pixel_expander #(
    parameter int BUF_SIZE = 1280,
    parameter int ADDR_W   = 11
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [7:0]        wr_bitmap_on,
    input  logic [7:0]        wr_bitmap_off,
    input  logic [3:0]        wr_bitmap_bits,
    output logic              wr_busy,
    output logic              pix_wr_en,
    output logic [ADDR_W-1:0] pix_wr_addr,
    output logic [7:0]        pix_wr_data
);

    typedef enum logic {
        IDLE,
        EXPAND
    } state_t;

    state_t state, state_next;

    // Latched request context
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        on_q, on_d;
    logic [7:0]        off_q, off_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        rem_q, rem_d;    // pixels still to emit after the current one

    // Pixel being emitted at the next edge
    logic              px_fire;
    logic              px_transparent;
    logic [ADDR_W-1:0] px_addr;
    logic [7:0]        px_data;
    logic              pix_en_d;

    logic              accept;
    logic [3:0]        count;

    // wr_busy is exactly the EXPAND state register, so it is a registered output.
    assign wr_busy = (state == EXPAND);
    assign accept  = wr_en && !wr_busy;
    assign count   = (wr_bitmap_bits > 4'd8) ? 4'd8 : wr_bitmap_bits;

    // State register
    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: stay in EXPAND until the last pixel is being issued
    always_comb begin
        // NOTE: default first so no path through the block leaves the signal
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        case (state)
            IDLE:    if (accept && count > 4'd1) state_next = EXPAND;
            EXPAND:  if (rem_q == 3'd1)          state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: select the pixel to emit and the next datapath contents
    always_comb begin
        px_fire        = 1'b0;
        px_transparent = 1'b0;
        px_addr        = addr_q;
        px_data        = pix_wr_data;
        shift_d        = shift_q;
        on_d           = on_q;
        off_d          = off_q;
        addr_d         = addr_q;
        rem_d          = rem_q;

        if (state == IDLE) begin
            if (accept) begin
                px_fire = 1'b1;
                px_addr = wr_addr;
                on_d    = wr_bitmap_on;
                off_d   = wr_bitmap_off;
                shift_d = {wr_data[6:0], 1'b0};
                addr_d  = wr_addr + 1'b1;
                if (count == 4'd0) begin
                    px_data = wr_data;
                    rem_d   = 3'd0;
                end else begin
                    px_data = wr_data[7] ? wr_bitmap_on : wr_bitmap_off;
                    rem_d   = 3'(count - 4'd1);
`ifdef CHRONI_EXPANDER_TRANSPARENT_EN
                    px_transparent = !wr_data[7] && (wr_bitmap_off == 8'h00);
`endif
                end
            end
        end else begin
            px_fire = 1'b1;
            px_addr = addr_q;
            px_data = shift_q[7] ? on_q : off_q;
            shift_d = {shift_q[6:0], 1'b0};
            addr_d  = addr_q + 1'b1;
            rem_d   = rem_q - 3'd1;
`ifdef CHRONI_EXPANDER_TRANSPARENT_EN
            px_transparent = !shift_q[7] && (off_q == 8'h00);
`endif
        end

        // Out-of-buffer and transparent pixels still consume their cycle.
        pix_en_d = px_fire && !px_transparent && (32'(px_addr) < 32'(BUF_SIZE));
    end

    // Datapath and pixel RAM port registers; address/data only move on a real write
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            shift_q     <= 8'h00;
            on_q        <= 8'h00;
            off_q       <= 8'h00;
            addr_q      <= '0;
            rem_q       <= 3'd0;
            pix_wr_en   <= 1'b0;
            pix_wr_addr <= '0;
            pix_wr_data <= 8'h00;
        end else begin
            shift_q   <= shift_d;
            on_q      <= on_d;
            off_q     <= off_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            pix_wr_en <= pix_en_d;
            if (pix_en_d) begin
                pix_wr_addr <= px_addr;
                pix_wr_data <= px_data;
            end
        end
    end

endmodule

// File: tb/tb_chroni_pixel_expander.sv
// Self-checking bench for chroni_pixel_expander. Each request's expected
// pixel writes are pushed onto a scoreboard queue when it is driven; a monitor
// pops and compares them as the DUT issues pix_wr_en strobes.

module tb_chroni_pixel_expander;

    localparam int BUF_SIZE = 1280;
    localparam int ADDR_W   = 11;

    logic              sys_clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [7:0]        wr_bitmap_on;
    logic [7:0]        wr_bitmap_off;
    logic [3:0]        wr_bitmap_bits;
    logic              wr_busy;
    logic              pix_wr_en;
    logic [ADDR_W-1:0] pix_wr_addr;
    logic [7:0]        pix_wr_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [ADDR_W+7:0] exp_q[$];     // {addr, data}
    int                wr_cyc_q[$];  // cycle number of every observed write

    chroni_pixel_expander #(.BUF_SIZE(BUF_SIZE), .ADDR_W(ADDR_W)) dut (
        .sys_clk        (sys_clk),
        .reset          (reset),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_bitmap_on   (wr_bitmap_on),
        .wr_bitmap_off  (wr_bitmap_off),
        .wr_bitmap_bits (wr_bitmap_bits),
        .wr_busy        (wr_busy),
        .pix_wr_en      (pix_wr_en),
        .pix_wr_addr    (pix_wr_addr),
        .pix_wr_data    (pix_wr_data)
    );

    always #5 sys_clk = ~sys_clk;

    // Scoreboard monitor: compare each DUT write against the oldest expected one
    always @(posedge sys_clk) begin
        logic [ADDR_W+7:0] e;
        cyc = cyc + 1;
        #1;
        if (pix_wr_en === 1'b1) begin
            wr_cyc_q.push_back(cyc);
            total = total + 1;
            if (exp_q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL unexpected_write: got addr=%0d data=%h, none expected", pix_wr_addr, pix_wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({pix_wr_addr, pix_wr_data} !== e) begin
                    bad = bad + 1;
                    $display("FAIL pixel_write: got addr=%0d data=%h, want addr=%0d data=%h",
                             pix_wr_addr, pix_wr_data, e[ADDR_W+7:8], e[7:0]);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    // Reference model: push the writes a request should produce (first maxpix pixels)
    task automatic model(input logic [ADDR_W-1:0] a, input logic [7:0] d, input logic [7:0] on,
                         input logic [7:0] off, input logic [3:0] bits, input int maxpix);
        int n;
        logic [ADDR_W-1:0] ad;
        logic [7:0] px;
        logic b;
        logic skip;
        n = (bits == 4'd0) ? 1 : ((bits > 4'd8) ? 8 : int'(bits));
        for (int k = 0; k < n && k < maxpix; k++) begin
            ad   = a + ADDR_W'(k);
            b    = d[7-k];
            px   = (bits == 4'd0) ? d : (b ? on : off);
            skip = (int'(ad) >= BUF_SIZE);
`ifdef CHRONI_EXPANDER_TRANSPARENT_EN
            if (bits != 4'd0 && !b && off == 8'h00) skip = 1'b1;
`endif
            if (!skip) exp_q.push_back({ad, px});
        end
    endtask

    // Present one request for exactly one edge
    task automatic send(input logic [ADDR_W-1:0] a, input logic [7:0] d, input logic [7:0] on,
                        input logic [7:0] off, input logic [3:0] bits);
        wr_en          = 1'b1;
        wr_addr        = a;
        wr_data        = d;
        wr_bitmap_on   = on;
        wr_bitmap_off  = off;
        wr_bitmap_bits = bits;
        step(1);
        wr_en          = 1'b0;
        wr_addr        = '1;
        wr_data        = 8'hxx;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        wr_en = 1'b0;
        wr_addr = '0; wr_data = 8'h00; wr_bitmap_on = 8'h00; wr_bitmap_off = 8'h00; wr_bitmap_bits = 4'd0;
        step(2);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            total = total + 1;
            if (wr_busy !== 1'b0 || pix_wr_en !== 1'b0 || pix_wr_addr !== '0) begin
                bad = bad + 1;
                $display("FAIL reset_idle cycle %0d: got busy=%b en=%b addr=%0d, want 0 0 0",
                         i, wr_busy, pix_wr_en, pix_wr_addr);
            end
            step(1);
        end
    endtask

    task automatic test_expand8;
        model(11'd0, 8'hA5, 8'h0F, 8'h01, 4'd8, 8);
        send(11'd0, 8'hA5, 8'h0F, 8'h01, 4'd8);
        for (int k = 0; k < 8; k++) begin
            total = total + 1;
            if (wr_busy !== (k < 7)) begin
                bad = bad + 1;
                $display("FAIL expand8_busy pixel %0d: got %b want %b", k, wr_busy, (k < 7));
            end
            step(1);
        end
        total = total + 1;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL expand8_drained: %0d writes missing, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back;
        wr_cyc_q.delete();
        model(11'd0, 8'h3C, 8'h21, 8'h42, 4'd8, 8);
        model(11'd8, 8'h81, 8'h63, 8'h84, 4'd8, 8);
        send(11'd0, 8'h3C, 8'h21, 8'h42, 4'd8);
        // Requests while busy must be dropped
        wr_en = 1'b1; wr_addr = 11'd100; wr_data = 8'hFF; wr_bitmap_on = 8'hEE; wr_bitmap_bits = 4'd8;
        step(3);
        wr_en = 1'b0;
        step(4);
        total = total + 1;
        if (wr_busy !== 1'b0 || pix_wr_en !== 1'b1 || pix_wr_addr !== 11'd7) begin
            bad = bad + 1;
            $display("FAIL b2b_last_pixel: got busy=%b en=%b addr=%0d, want 0 1 7", wr_busy, pix_wr_en, pix_wr_addr);
        end
        send(11'd8, 8'h81, 8'h63, 8'h84, 4'd8);
        step(9);
        total = total + 1;
        if (wr_cyc_q.size() != 16 || wr_cyc_q[wr_cyc_q.size()-1] - wr_cyc_q[0] != 15) begin
            bad = bad + 1;
            $display("FAIL b2b_contiguous: got %0d writes, want 16 in 16 consecutive cycles", wr_cyc_q.size());
        end
        total = total + 1;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL b2b_drained: %0d writes missing, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_direct_and_short;
        model(11'd640, 8'h37, 8'h99, 8'h88, 4'd0, 8);
        send(11'd640, 8'h37, 8'h99, 8'h88, 4'd0);
        for (int k = 0; k < 3; k++) begin
            total = total + 1;
            if (wr_busy !== 1'b0) begin
                bad = bad + 1;
                $display("FAIL direct_busy cycle %0d: got %b want 0", k, wr_busy);
            end
            step(1);
        end
        model(11'd300, 8'hC0, 8'hAA, 8'h55, 4'd3, 8);
        send(11'd300, 8'hC0, 8'hAA, 8'h55, 4'd3);
        for (int k = 0; k < 3; k++) begin
            total = total + 1;
            if (wr_busy !== (k < 2)) begin
                bad = bad + 1;
                $display("FAIL bits3_busy pixel %0d: got %b want %b", k, wr_busy, (k < 2));
            end
            step(1);
        end
        // Out-of-range count clamps to 8 pixels
        model(11'd400, 8'h6B, 8'h12, 8'h34, 4'd15, 8);
        send(11'd400, 8'h6B, 8'h12, 8'h34, 4'd15);
        step(9);
        total = total + 1;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL direct_short_drained: %0d writes missing, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_boundary;
        model(11'd1276, 8'h96, 8'h11, 8'h22, 4'd8, 8);
        send(11'd1276, 8'h96, 8'h11, 8'h22, 4'd8);
        for (int k = 0; k < 8; k++) begin
            total = total + 1;
            if (wr_busy !== (k < 7)) begin
                bad = bad + 1;
                $display("FAIL edge_busy pixel %0d: got %b want %b", k, wr_busy, (k < 7));
            end
            step(1);
        end
        total = total + 1;
        if (pix_wr_addr !== 11'd1279 || pix_wr_en !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL edge_hold: got addr=%0d en=%b, want 1279 0", pix_wr_addr, pix_wr_en);
        end
        model(11'd2046, 8'h5A, 8'h77, 8'h66, 4'd8, 8);
        send(11'd2046, 8'h5A, 8'h77, 8'h66, 4'd8);
        step(9);
        total = total + 1;
        if (pix_wr_addr !== 11'd5 || exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL wrap: got last addr=%0d pending=%0d, want 5 0", pix_wr_addr, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid;
        model(11'd50, 8'hFF, 8'h5E, 8'h11, 4'd8, 3);
        send(11'd50, 8'hFF, 8'h5E, 8'h11, 4'd8);
        step(2);
        reset = 1'b1;
        step(1);
        total = total + 1;
        if (pix_wr_en !== 1'b0 || wr_busy !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL reset_mid: got en=%b busy=%b, want 0 0", pix_wr_en, wr_busy);
        end
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            total = total + 1;
            if (pix_wr_en !== 1'b0 || wr_busy !== 1'b0) begin
                bad = bad + 1;
                $display("FAIL reset_mid_after cycle %0d: got en=%b busy=%b, want 0 0", k, pix_wr_en, wr_busy);
            end
            step(1);
        end
        total = total + 1;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL reset_mid_drained: %0d writes missing, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_transparent;
        model(11'd20, 8'hF0, 8'h33, 8'h00, 4'd8, 8);
        send(11'd20, 8'hF0, 8'h33, 8'h00, 4'd8);
        step(9);
        total = total + 1;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL transparent_drained: %0d writes missing, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_expand8();
        test_back_to_back();
        test_direct_and_short();
        test_boundary();
        test_reset_mid();
        test_transparent();
        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
